// File: rtl/pe_mac.sv
// Signed multiply-accumulate PE: 1 multiply stage, 1 accumulate/output stage.
// Latency 2 cycles from last beat to out_valid; a stalled output register freezes the whole pipe.
// Backpressure: in_ready = (!out_valid || out_ready) && !clr, combinational from out_ready.
module pe_mac #(
    parameter int IWIDTH = 8,
    parameter int WWIDTH = 8,
    parameter int AWIDTH = 24,
    parameter int OWIDTH = 16,
    parameter int SHW    = $clog2(AWIDTH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic signed [IWIDTH-1:0] ifm_in,
    input  logic signed [WWIDTH-1:0] wgt_in,
    input  logic        [SHW-1:0]    cfg_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OWIDTH-1:0] out_data,
    output logic                     out_sat
);

    localparam int PW = IWIDTH + WWIDTH;
    localparam logic signed [AWIDTH-1:0] OMAX = {{(AWIDTH-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH-1:0] OMIN = {{(AWIDTH-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

    logic signed [PW-1:0]     p1_q, p1_d;
    logic                     v1_q, v1_d;
    logic                     l1_q, l1_d;
    logic        [SHW-1:0]    s1_q, s1_d;
    logic signed [AWIDTH-1:0] acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OWIDTH-1:0] out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;

    logic                     en;
    logic                     load;
    logic signed [AWIDTH-1:0] sum;
    logic signed [AWIDTH-1:0] shr;

    always_comb begin
        en       = !out_valid_q || out_ready;
        in_ready = en && !clr;
        sum      = acc_q + AWIDTH'(p1_q);
        shr      = sum >>> s1_q;
        load     = en && v1_q && l1_q && !clr;

        p1_d        = p1_q;
        v1_d        = v1_q;
        l1_d        = l1_q;
        s1_d        = s1_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q && !out_ready;

        // clr drops the in-flight beat and the partial sum but never touches the output register
        if (clr) begin
            v1_d  = 1'b0;
            acc_d = '0;
        end else if (en) begin
            p1_d = PW'(ifm_in) * PW'(wgt_in);
            v1_d = in_valid;
            l1_d = in_last;
            s1_d = cfg_shift;
            if (v1_q) begin
                acc_d = l1_q ? '0 : sum;
            end
        end

        if (load) begin
            out_valid_d = 1'b1;
            if (shr > OMAX) begin
                out_data_d = OMAX[OWIDTH-1:0];
                out_sat_d  = 1'b1;
            end else if (shr < OMIN) begin
                out_data_d = OMIN[OWIDTH-1:0];
                out_sat_d  = 1'b1;
            end else begin
                out_data_d = shr[OWIDTH-1:0];
                out_sat_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p1_q        <= '0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            s1_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            p1_q        <= p1_d;
            v1_q        <= v1_d;
            l1_q        <= l1_d;
            s1_q        <= s1_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pe_mac.sv
// Directed and randomized bench for pe_mac against a group-level arithmetic model.
module tb_pe_mac;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic signed [7:0] ifm_in = '0;
    logic signed [7:0] wgt_in = '0;
    logic        [4:0] cfg_shift = '0;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] out_data;
    logic              out_sat;

    logic ordy_man = 1'b1;
    logic rand_bp  = 1'b0;
    logic rnd_ordy = 1'b1;
    assign out_ready = rand_bp ? rnd_ordy : ordy_man;

    int    checks = 0;
    int    errors = 0;
    int    n_out  = 0;
    int    n_exp  = 0;
    longint grp_sum = 0;

    typedef struct {
        int data;
        bit sat;
    } res_t;
    res_t exp_q[$];

    pe_mac dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .ifm_in    (ifm_in),
        .wgt_in    (wgt_in),
        .cfg_shift (cfg_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        rnd_ordy = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Group result from the arithmetic rules: wrap to 24 bits, floor shift, clamp to 16 bits.
    function automatic res_t model(input longint s, input int sh);
        res_t x;
        logic signed [23:0] w;
        longint r;
        w = s[23:0];
        r = longint'(w) >>> sh;
        if (r > 32767) begin
            x.data = 32767;  x.sat = 1'b1;
        end else if (r < -32768) begin
            x.data = -32768; x.sat = 1'b1;
        end else begin
            x.data = int'(r); x.sat = 1'b0;
        end
        return x;
    endfunction

    task automatic beat(input int a, input int b, input int sh, input bit last);
        int n;
        n = 0;
        ifm_in    = 8'(a);
        wgt_in    = 8'(b);
        cfg_shift = 5'(sh);
        in_last   = last;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $error("FAIL beat_accept: observed in_ready=%0d after %0d cycles expected 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        grp_sum += longint'(a) * longint'(b);
        if (last) begin
            exp_q.push_back(model(grp_sum, sh));
            n_exp++;
            grp_sum = 0;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL %s: observed out_valid=%0d expected 1 within 50 cycles", tag, out_valid);
        end
    endtask

    task automatic expect_out(input string tag, input int d, input bit s);
        wait_valid(tag);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_sat"}, out_sat, s);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            n++;
            @(posedge clk);
        end
        #1;
        chk(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL mon_unexpected: observed data %0d expected no output", out_data);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("mon_data", out_data, e.data);
                chk("mon_sat", out_sat, e.sat);
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // single beat and latency
        beat(-128, -128, 0, 1);
        chk("lat_edge1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_edge2_valid", out_valid, 1);
        chk("single_data", out_data, 16384);
        chk("single_sat", out_sat, 0);
        @(posedge clk);
        #1;

        // 4 x 100*100 with shift 0 and 2
        for (int i = 0; i < 4; i++) beat(100, 100, 0, i == 3);
        expect_out("sum_sat", 32767, 1);
        for (int i = 0; i < 4; i++) beat(100, 100, 2, i == 3);
        expect_out("sum_shift2", 10000, 0);

        // floor shift and negative saturation
        beat(-3, 5, 1, 1);
        expect_out("floor", -8, 0);
        for (int i = 0; i < 4; i++) beat(-128, 127, 0, i == 3);
        expect_out("neg_sat", -32768, 1);

        // backpressure with 1-beat groups
        ordy_man = 1'b0;
        beat(7, 1, 0, 1);
        beat(9, 1, 0, 1);
        ifm_in = 8'sd11; wgt_in = 8'sd1; cfg_shift = '0; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 7);
        end
        @(posedge clk);
        #1;
        ordy_man = 1'b1;
        beat(11, 1, 0, 1);
        drain("bp_drain");

        // clr with a pending result, then clr mid-group
        ordy_man = 1'b0;
        beat(5, 5, 0, 1);
        wait_valid("clr_pend");
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_pend_valid", out_valid, 1);
        chk("clr_pend_data", out_data, 25);
        ordy_man = 1'b1;
        drain("clr_pend_drain");
        beat(10, 10, 0, 0);
        beat(10, 10, 0, 0);
        clr = 1'b1;
        #1;
        chk("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        grp_sum = 0;
        beat(1, 1, 0, 1);
        expect_out("clr_new", 1, 0);

        // async reset mid-group with a pending result
        ordy_man = 1'b0;
        beat(4, 4, 0, 1);
        beat(2, 2, 0, 0);
        wait_valid("rst_pend");
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_in_ready", in_ready, 1);
        n_exp -= exp_q.size();
        exp_q.delete();
        grp_sum = 0;
        @(negedge clk);
        rstn = 1'b1;
        ordy_man = 1'b1;
        @(posedge clk);
        #1;
        beat(2, 3, 0, 1);
        expect_out("post_rst", 6, 0);

        // randomized groups under random backpressure
        rand_bp = 1'b1;
        for (int g = 0; g < 40; g++) begin
            int len;
            int shl;
            len = $urandom_range(1, 6);
            shl = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     (i == len - 1) ? shl : int'($urandom_range(0, 31)), i == len - 1);
            end
        end
        rand_bp = 1'b0;
        ordy_man = 1'b1;
        drain("rand_drain");
        chk("out_count", n_out, n_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_mac.md
# pe_mac

Parametrised signed multiply-accumulate processing element for the convolution array. It is the successor to the single-product PE. It accepts a stream of ifm/wgt pairs under a valid/ready handshake and accumulates products over a group delimited by `in_last`. At the end of each group it emits one arithmetically shifted, saturated result through a single-entry output register with backpressure.

## Interface
Parameters:
- IWIDTH, 8, signed ifm operand width
- WWIDTH, 8, signed weight operand width
- AWIDTH, 24, signed accumulator width; must satisfy AWIDTH >= IWIDTH+WWIDTH
- OWIDTH, 16, signed output width; must satisfy OWIDTH <= AWIDTH
- SHW, $clog2(AWIDTH), width of `cfg_shift`

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush of the pipeline and accumulator
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_last  in  1  beat is the final one of its accumulation group
- ifm_in  in  IWIDTH  signed feature operand
- wgt_in  in  WWIDTH  signed weight operand
- cfg_shift  in  SHW  arithmetic right shift applied to the group result
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer takes the result when out_valid && out_ready
- out_data  out  OWIDTH  signed, shifted, saturated group sum
- out_sat  out  1  saturation occurred for the result in out_data

## Operation
- Advance enable: `en = !out_valid || out_ready`. `in_ready = en`. In the reference design, in_ready also drops while `clr` is high.
- Stage 1 (S1): registers on `en`:
  - p1 = ifm_in*wgt_in, full IWIDTH+WWIDTH signed product;
  - v1 = in_valid && in_ready;
  - l1 = in_last;
  - s1 = cfg_shift.
  - cfg_shift is sampled per beat and only the last beat's value is used.
- Stage 2 (accumulate), on `en && v1`:
  - sum = acc + sext(p1) in AWIDTH bits. The accumulator wraps modulo 2^AWIDTH; there is no accumulator saturation.
  - If !l1: acc <= sum.
  - If l1:
    - r = sum >>> s1, arithmetic shift with floor (no rounding). A shift of AWIDTH or more gives 0 or -1.
    - out_data <= clamp(r, -2^(OWIDTH-1), 2^(OWIDTH-1)-1).
    - out_sat <= (r outside that range).
    - out_valid <= 1; acc <= 0.
- Output register: out_valid clears on handshake unless a new result loads in the same cycle. Load and drain in the same cycle are permitted, giving back-to-back results.
- When en=0 the whole pipeline holds: S1, acc and output are frozen and no beat is accepted.
- clr=1 (priority over en):
  - v1 <= 0 and acc <= 0; the partial group is discarded.
  - The output register and out_valid are unaffected; a pending result is still delivered.
- A group of length 1 (in_last on its first beat) is legal.
- Back-to-back groups need no idle cycle between them.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0, acc=0, v1=0, p1=0, l1=0, s1=0. The reset value of in_ready reflects out_valid=0.
- Latency: the last beat accepted at edge t produces out_valid=1 after edge t+1, i.e. 2 cycles.
- Throughput: 1 beat/cycle while out_ready=1. A 1-beat group can be issued every cycle.
- Stall: out_valid=1 && out_ready=0 gives in_ready=0 in the same cycle (combinational); in-flight S1 data holds.
- Reset mid-group: all state returns to the reset values immediately and asynchronously; the partial sum is lost.

## Test plan
All scenarios use default parameters.
- Single beat, in_last=1, ifm=-128, wgt=-128, shift=0 -> out_data=16384, out_sat=0, out_valid 2 cycles after accept.
- Four beats of 100*100, last on beat 4:
  - shift=0 -> out_data=32767, out_sat=1;
  - the same group with shift=2 -> out_data=10000, out_sat=0.
- Beat ifm=-3, wgt=5, shift=1, last -> out_data=-8 (floor), out_sat=0. Four beats of -128*127 with shift=0 -> out_data=-32768, out_sat=1.
- Backpressure: out_ready=0 with two 1-beat groups (values 7 then 9) -> first result holds, in_ready=0, second beat waits; after out_ready=1, outputs 7 then 9 with none lost or duplicated.
- clr after 2 beats of 10*10, then a new group 1*1 last -> out_data=1. A result pending during clr is still delivered unchanged.
- rstn low mid-group with out_valid=1 -> out_valid=0, out_data=0 immediately; after release, a 2*3 group -> out_data=6.
